uart_frame_decoder: RTL

Parametrised successor to the fixed 3-opcode UART byte decoder. Accepts received bytes only on an rx_valid strobe from the UART receiver and reassembles N_FIELDS multi-fragment position fields with ordering checks. Updates each field atomically, with a per-field update pulse. Adds a link-loss watchdog on sync bytes. Sits between the uart RX core and the game control/draw logic.

---
 rtl/uart_proto_pkg.sv | 26 ++
 rtl/uart_field_assembler.sv | 100 ++++++++++
 rtl/uart_frame_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_proto_pkg.sv
// Shared protocol constants for the UART frame decoder: opcodes, sync
// patterns, status bit layout and the fragment assembler state type.
package uart_proto_pkg;

  localparam int OPC_SYNC = 0;

  localparam int SYNC_W = 5;
  localparam logic [SYNC_W-1:0] SYNC_SHOOTER_START = 5'b11001;
  localparam logic [SYNC_W-1:0] SYNC_KEEPER_START  = 5'b01001;
  localparam logic [SYNC_W-1:0] SYNC_IDLE          = 5'b00001;

  localparam int STATUS_SCORE_LSB = 0;
  localparam int STATUS_SCORE_W   = 3;
  localparam int STATUS_SHOT_BIT  = 3;

  typedef enum logic {
    ASM_IDLE    = 1'b0,
    ASM_COLLECT = 1'b1
  } asm_state_e;

  // The status opcode is always the top code of the opcode space.
  function automatic int opc_status(input int opcode_w);
    return (1 << opcode_w) - 1;
  endfunction

endpackage

// File: rtl/uart_field_assembler.sv
// Reassembles one multi-fragment field. Parts must arrive in order
// 0..PARTS-1; the visible field only changes on the final part.
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   ASM_IDLE    | no partial held, only part 0 is acceptable
//   ASM_COLLECT | partial held, waiting for part exp_q
module uart_field_assembler
  import uart_proto_pkg::*;
#(
  parameter int PW    = 5,
  parameter int PARTS = 2,
  localparam int IDX_W   = (PARTS > 1) ? $clog2(PARTS) : 1,
  localparam int FIELD_W = PW * PARTS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               frag_valid,
  input  logic [IDX_W-1:0]   part_idx,
  input  logic [PW-1:0]      part_data,
  output logic [FIELD_W-1:0] data,
  output logic               upd,
  output logic               err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PARTS - 1);

  asm_state_e         state_q, state_d;
  logic [IDX_W-1:0]   exp_q, exp_d;
  logic [FIELD_W-1:0] shadow_q, shadow_d;
  logic [FIELD_W-1:0] data_q, data_d;
  logic               upd_q, upd_d;
  logic               err_q, err_d;
  logic [FIELD_W-1:0] merged;

  // Shadow with the incoming part dropped into its slot.
  always_comb begin
    merged = shadow_q;
    for (int i = 0; i < PARTS; i++) begin
      if (part_idx == IDX_W'(i)) merged[i*PW +: PW] = part_data;
    end
  end

  // Next-state: part 0 always (re)starts, the expected part advances,
  // anything else drops the partial and flags an error.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    if (clr) begin
      state_d = ASM_IDLE;
      exp_d   = '0;
    end else if (frag_valid) begin
      if (part_idx == '0 || (state_q == ASM_COLLECT && part_idx == exp_q)) begin
        shadow_d = merged;
        if (part_idx == LAST_IDX) begin
          data_d  = merged;
          upd_d   = 1'b1;
          state_d = ASM_IDLE;
          exp_d   = '0;
        end else begin
          state_d = ASM_COLLECT;
          exp_d   = part_idx + 1'b1;
        end
      end else begin
        err_d   = 1'b1;
        state_d = ASM_IDLE;
        exp_d   = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ASM_IDLE;
      exp_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign data = data_q;
  assign upd  = upd_q;
  assign err  = err_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes strobed UART bytes into link status, game status and N_FIELDS
// reassembled position fields, with a watchdog on sync bytes.
module uart_frame_decoder
  import uart_proto_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int OPCODE_W       = 3,
  parameter int N_FIELDS       = 3,
  parameter int PARTS          = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  localparam int PW      = DATA_W - OPCODE_W,
  localparam int FIELD_W = PARTS * PW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [DATA_W-1:0]             rx_data,
  output logic                          connected,
  output logic                          enemy_shooter,
  output logic                          game_starts,
  output logic [N_FIELDS*FIELD_W-1:0]   field_data,
  output logic [N_FIELDS-1:0]           field_upd,
  output logic [2:0]                    opponent_score,
  output logic                          is_shooted,
  output logic                          frag_err,
  output logic                          link_lost
);

  localparam int OPC_STATUS = opc_status(OPCODE_W);
  localparam int N_FRAGS    = N_FIELDS * PARTS;
  localparam int IDX_W      = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [OPCODE_W-1:0] OP_SYNC      = OPCODE_W'(OPC_SYNC);
  localparam logic [OPCODE_W-1:0] OP_STATUS    = OPCODE_W'(OPC_STATUS);
  localparam logic [OPCODE_W-1:0] OP_FRAG_LAST = OPCODE_W'(N_FRAGS);
  localparam logic [CNT_W-1:0]    CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  if (N_FRAGS + 2 > 2**OPCODE_W) begin : g_bad_opcode_space
    $error("uart_frame_decoder: N_FIELDS*PARTS+2 exceeds opcode space");
  end
  if (PW < 5) begin : g_bad_payload
    $error("uart_frame_decoder: payload narrower than sync pattern");
  end

  logic [OPCODE_W-1:0] op;
  logic [PW-1:0]       pl;
  logic [OPCODE_W-1:0] frag_num;
  logic [IDX_W-1:0]    frag_idx;
  int                  frag_f;
  int                  frag_k;
  logic                is_sync, is_frag, is_unused, is_status, sync_ok;
  logic                wd_expire, lost_now;

  logic                connected_q, connected_d;
  logic                enemy_q, enemy_d;
  logic                game_q, game_d;
  logic [2:0]          score_q, score_d;
  logic                shot_q, shot_d;
  logic                unused_err_q, unused_err_d;
  logic                link_lost_q, link_lost_d;
  logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [N_FIELDS-1:0] asm_err;

  assign op = rx_data[OPCODE_W-1:0];
  assign pl = rx_data[DATA_W-1:OPCODE_W];

  // Opcode classification and fragment routing (field index, part index).
  always_comb begin
    is_sync   = rx_valid && (op == OP_SYNC);
    is_status = rx_valid && (op == OP_STATUS);
    is_frag   = rx_valid && (op != OP_SYNC) && (op <= OP_FRAG_LAST);
    is_unused = rx_valid && (op > OP_FRAG_LAST) && (op != OP_STATUS);
    sync_ok   = is_sync && (pl[SYNC_W-1:0] == SYNC_SHOOTER_START ||
                            pl[SYNC_W-1:0] == SYNC_KEEPER_START  ||
                            pl[SYNC_W-1:0] == SYNC_IDLE);
    frag_num  = op - OPCODE_W'(1);
    frag_f    = int'(frag_num) / PARTS;
    frag_k    = int'(frag_num) % PARTS;
    frag_idx  = IDX_W'(frag_k);
    wd_expire = connected_q && (wd_cnt_q == CNT_LAST);
    // A valid sync on the expiry cycle keeps the link alive.
    lost_now  = wd_expire && !sync_ok;
  end

  for (genvar gf = 0; gf < N_FIELDS; gf++) begin : g_field
    logic frag_hit;
    assign frag_hit = is_frag && (frag_f == gf);

    uart_field_assembler #(
      .PW    (PW),
      .PARTS (PARTS)
    ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (lost_now),
      .frag_valid (frag_hit),
      .part_idx   (frag_idx),
      .part_data  (pl),
      .data       (field_data[gf*FIELD_W +: FIELD_W]),
      .upd        (field_upd[gf]),
      .err        (asm_err[gf])
    );
  end

  // Next-state for link flags, status, unused-opcode error and watchdog.
  always_comb begin
    connected_d  = connected_q;
    enemy_d      = enemy_q;
    game_d       = game_q;
    score_d      = score_q;
    shot_d       = shot_q;
    unused_err_d = is_unused;
    link_lost_d  = lost_now;
    wd_cnt_d     = connected_q ? wd_cnt_q + 1'b1 : '0;

    if (sync_ok) begin
      connected_d = 1'b1;
      enemy_d     = (pl[SYNC_W-1:0] == SYNC_SHOOTER_START);
      game_d      = (pl[SYNC_W-1:0] != SYNC_IDLE);
      wd_cnt_d    = '0;
    end else if (lost_now || is_sync) begin
      connected_d = 1'b0;
      enemy_d     = 1'b0;
      game_d      = 1'b0;
      if (lost_now) wd_cnt_d = '0;
    end

    if (is_status) begin
      score_d = pl[STATUS_SCORE_LSB +: STATUS_SCORE_W];
      shot_d  = pl[STATUS_SHOT_BIT];
    end
  end

  // Registers for everything the top level owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      connected_q  <= 1'b0;
      enemy_q      <= 1'b0;
      game_q       <= 1'b0;
      score_q      <= '0;
      shot_q       <= 1'b0;
      unused_err_q <= 1'b0;
      link_lost_q  <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      connected_q  <= connected_d;
      enemy_q      <= enemy_d;
      game_q       <= game_d;
      score_q      <= score_d;
      shot_q       <= shot_d;
      unused_err_q <= unused_err_d;
      link_lost_q  <= link_lost_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign connected      = connected_q;
  assign enemy_shooter  = enemy_q;
  assign game_starts    = game_q;
  assign opponent_score = score_q;
  assign is_shooted     = shot_q;
  assign link_lost      = link_lost_q;
  assign frag_err       = unused_err_q | (|asm_err);

endmodule
